// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : types and helpers shared by uart_tx and uart_rx
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic int baud_limit(input int clkf, input int baud);
        return (clkf / baud) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : 2-flop synchronizer for the RX pin plus falling-edge detect
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic rxs_i,
    output logic rxs_s_o,
    output logic fall_o
);

    logic meta_q;
    logic rxs_s_q;
    logic prev_q;

    // Flops reset to the idle-high level so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_q  <= 1'b1;
            rxs_s_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            meta_q  <= rxs_i;
            rxs_s_q <= meta_q;
            prev_q  <= rxs_s_q;
        end
    end

    assign rxs_s_o = rxs_s_q;
    assign fall_o  = prev_q & ~rxs_s_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : oversampling UART receiver with valid/ready output port
//           UART_RX_MAJORITY_EN selects a 2-of-3 vote around each sample point
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD   = 921600,
    parameter int CLKF   = 100000000,
    parameter int DLEN   = 8,
    parameter int PARITY = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_rxs,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [DLEN-1:0] o_rdata,
    output logic            o_perr,
    output logic            o_ferr,
    output logic            o_overrun
);

    localparam int BAUD_LIMIT = baud_limit(CLKF, BAUD);
    localparam int HALF_LIMIT = BAUD_LIMIT / 2;
    localparam int CW         = (BAUD_LIMIT > 0) ? $clog2(BAUD_LIMIT + 1) : 1;
    localparam int BW         = (DLEN > 1) ? $clog2(DLEN) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_LIMIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_LIMIT);
    localparam logic [BW-1:0] BIT_LAST = BW'(DLEN - 1);

    logic rxs_s;
    logic fall;
    logic start;
    logic sample;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .rxs_i   (i_rxs),
        .rxs_s_o (rxs_s),
        .fall_o  (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // Whole receiver runs one cycle late so the vote can see limit+1
    logic [1:0] hist_q;
    logic       fall_dly_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hist_q     <= 2'b11;
            fall_dly_q <= 1'b0;
        end else begin
            hist_q     <= {hist_q[0], rxs_s};
            fall_dly_q <= fall;
        end
    end

    assign start  = fall_dly_q;
    assign sample = (rxs_s & hist_q[0]) | (rxs_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign start  = fall;
    assign sample = rxs_s;
`endif

    rx_state_e       state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [BW-1:0]   bitcnt_q,  bitcnt_d;
    logic [DLEN-1:0] shift_q,   shift_d;
    logic            pfail_q,   pfail_d;
    logic            rvalid_q,  rvalid_d;
    logic [DLEN-1:0] rdata_q,   rdata_d;
    logic            perr_q,    perr_d;
    logic            ferr_q,    ferr_d;
    logic            overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            pfail_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            pfail_q   <= pfail_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        pfail_d   = pfail_q;
        rvalid_d  = rvalid_q & ~i_rready;
        rdata_d   = rdata_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        overrun_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // The edge cycle itself is tick 0 of the half-bit wait
                if (start) begin
                    state_d = RX_START;
                    cnt_d   = CW'(1);
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    pfail_d  = 1'b0;
                    state_d  = sample ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d             = '0;
                    shift_d           = shift_q >> 1;
                    shift_d[DLEN-1]   = sample;
                    bitcnt_d          = bitcnt_q + 1'b1;
                    if (bitcnt_q == BIT_LAST)
                        state_d = (PARITY == PARITY_EVEN) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    pfail_d = sample ^ (^shift_q);
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (!rvalid_q || i_rready) begin
                        rvalid_d = 1'b1;
                        rdata_d  = shift_q;
                        perr_d   = (PARITY == PARITY_NONE) ? 1'b0 : pfail_q;
                        ferr_d   = ~sample;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_rvalid  = rvalid_q;
    assign o_rdata   = rdata_q;
    assign o_perr    = perr_q;
    assign o_ferr    = ferr_q;
    assign o_overrun = overrun_q;

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the block `uart_tx`. It oversamples the asynchronous serial line with the system clock and reassembles start/data/optional-parity/stop frames. Each received word is presented on a valid/ready output port together with its parity and framing status. It sits between the board-level RX pin and the consuming logic, with the same frame format and parameters as `uart_tx`.

## Interface
- `BAUD`, 921600, line bit rate in bits/s
- `CLKF`, 100000000, `clk` frequency in Hz
- `DLEN`, 8, data bits per frame, LSB first
- `PARITY`, 0, 0 = no parity bit; 1 = one even-parity bit after the data
- `clk`  in  1  system clock
- `rstn`  in  1  reset, synchronous, active-low
- `i_rxs`  in  1  asynchronous serial line; idles high
- `o_rvalid`  out  1  received word available
- `i_rready`  in  1  consumer accepts the word
- `o_rdata`  out  DLEN  received word
- `o_perr`  out  1  parity mismatch for `o_rdata`; qualified by `o_rvalid`; always 0 when PARITY=0
- `o_ferr`  out  1  stop bit sampled low for `o_rdata`; qualified by `o_rvalid`
- `o_overrun`  out  1  one-cycle pulse: a completed frame was discarded because the output slot was full

## Operation
- **Synchronizer.** `i_rxs` passes through a 2-flop synchronizer (reset value 1) into `rxs_s`. A start edge is `rxs_s` = 0 with the previous `rxs_s` = 1.
- **Baud counter.**
  - `BaudLimit = CLKF/BAUD - 1`; `HalfLimit = BaudLimit/2`, using integer division.
  - The counter clears on every state change and on wrap.
  - A sample point occurs when the count reaches its limit.
- **States:**
  - RX_IDLE: on a start edge, go to RX_START.
  - RX_START: at `HalfLimit`, if `rxs_s` = 0, go to RX_DATA. Otherwise this is a false start; return to RX_IDLE.
  - RX_DATA: sample every `BaudLimit+1` cycles and shift the sample into bit `DLEN-1` with a right shift. After DLEN samples, go to RX_PARITY if PARITY=1, otherwise to RX_STOP.
  - RX_PARITY: sample one bit. `perr = sample ^ (^data)`.
  - RX_STOP: sample one bit. `ferr = !sample`. Go to RX_IDLE on that same cycle.
- **Delivery.** At the stop-bit sample point the frame completes:
  - If the slot is free, or is being emptied in this cycle (`o_rvalid && i_rready`), load `o_rdata`/`o_perr`/`o_ferr` and set `o_rvalid` on the next cycle.
  - Otherwise discard the frame, pulse `o_overrun`, and leave the held word untouched.
- **Error frames.** A frame with a framing error is still delivered, with `o_ferr` = 1.
- **Break / line stuck low.** RX_IDLE needs a high-to-low edge, so no new frame starts until the line has returned high.

## Timing
- **Reset values:** `o_rvalid`=0, `o_rdata`=0, `o_perr`=0, `o_ferr`=0, `o_overrun`=0. State is RX_IDLE and the synchronizer flops are 1.
- **Reset mid-frame:** the frame in progress is abandoned and nothing is delivered.
- **Sample points:** measured from the start edge seen on `rxs_s`, sample k (k = 0 for the start check) occurs at cycle `HalfLimit + k*(BaudLimit+1)`.
- **Latency:** `i_rxs` to `rxs_s` is 2 cycles. `o_rvalid` rises 1 cycle after the stop-bit sample point.
- **Handshake:**
  - A transfer occurs on `o_rvalid && i_rready`.
  - `o_rdata`, `o_perr` and `o_ferr` are stable while `o_rvalid` is high and `i_rready` is low.
  - `o_rvalid` falls on the cycle after a transfer, unless a new frame completes in the transfer cycle; then it stays high with the new word.
- **Back-to-back frames:** because the receiver returns to RX_IDLE at mid-stop, a start edge half a bit later is detected.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** each sample is the 2-of-3 majority of `rxs_s` at count limit-1, limit and limit+1. The decision is taken one cycle after the nominal sample point, so all data-valid timing shifts +1 cycle. The start check uses the same majority vote.
- **Undefined:** a single sample of `rxs_s` at the count limit.

## Structure
- **Shared package `uart_pkg`** (also used by `uart_tx`):
  - state enum `rx_state_e`
  - a function computing `BaudLimit` from CLKF/BAUD
  - the parity-enable constants
- **Sub-module `uart_rx_sync`:** 2-flop synchronizer plus start-edge detect. Outputs `rxs_s` and `fall`.

## Test plan
All scenarios use CLKF=100e6 and BAUD=921600, so BaudLimit=107 and HalfLimit=53.
- **Basic frame:** 0xA5, PARITY=0, `i_rready`=1 -> one cycle of `o_rvalid` with `o_rdata`=0xA5, `o_perr`=0, `o_ferr`=0, 1 cycle after the stop sample.
- **Parity:** PARITY=1. Send 0x07 with parity bit 1 -> `o_perr`=0. Send 0x07 with parity bit 0 -> `o_perr`=1, data still 0x07.
- **Framing error and break:** 0x3C with stop bit 0 -> `o_ferr`=1, `o_rdata`=0x3C. Then hold the line low for 20 bit times -> no further `o_rvalid`. Then release high and send 0x55 -> 0x55 received cleanly.
- **False start:** a 20-cycle low glitch while idle -> no `o_rvalid`, state back in RX_IDLE by cycle 54.
- **Overrun:** `i_rready`=0, send 0x11 then 0x22 -> `o_rdata` holds 0x11, `o_overrun` pulses at 0x22's stop sample. Then `i_rready`=1 -> 0x11 transferred, 0x22 never appears.
- **Reset mid-frame:** assert `rstn`=0 mid-data for 1 cycle -> all outputs at reset values, no delivery. The next frame 0xC3 is received correctly.
